packet_serializer: RTL and testbench

- Transmit-side counterpart of the byte-FIFO packet assembler.
- Accepts a 256-bit packet on a valid/ready handshake and writes it into a byte-wide FIFO write port as 32 consecutive bytes, most-significant byte first.
- Honours the FIFO full flag every cycle, so the FIFO never overflows.
- Sits between the controller's packet source and the write side of the byte FIFO.

---
 rtl/packet_serializer.sv | 87 ++++++++
 tb/tb_packet_serializer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_serializer.sv
// Byte serializer: accepts a 256-bit packet on valid/ready and writes it MSB-first
// into a byte-wide FIFO write port, stalling whenever the FIFO reports full.
module packet_serializer #(
  parameter int DATA_W = 256,
  parameter int BYTE_W = 8
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [DATA_W-1:0] packet_data,
  input  logic              packet_valid,
  output logic              packet_ready,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [BYTE_W-1:0] fifo_wdata,
  output logic              packet_done,
  output logic              busy,
  output logic [4:0]        byte_count
);

  localparam int         NUM_BYTES = DATA_W / BYTE_W;
  localparam logic [4:0] LAST_BYTE = 5'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] shift_reg;
  logic              accept;
  logic              last_write;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write strobe is gated by fifo_full in the same cycle so the FIFO can never overflow.
  always_comb begin
    state_next   = state;
    packet_ready = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wdata   = '0;
    accept       = 1'b0;
    last_write   = 1'b0;
    case (state)
      IDLE: begin
        packet_ready = 1'b1;
        accept       = packet_valid;
        if (packet_valid) state_next = SEND;
      end
      SEND: begin
        fifo_wr_en = !fifo_full;
        fifo_wdata = shift_reg[DATA_W-1 -: BYTE_W];
        last_write = !fifo_full && (byte_count == LAST_BYTE);
        if (last_write) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      shift_reg   <= '0;
      byte_count  <= '0;
      packet_done <= 1'b0;
    end else begin
      packet_done <= last_write;
      if (accept) begin
        shift_reg  <= packet_data;
        byte_count <= '0;
      end else if (fifo_wr_en) begin
        shift_reg  <= {shift_reg[DATA_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
        byte_count <= last_write ? 5'd0 : byte_count + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_packet_serializer.sv
// Bench for packet_serializer: per-cycle outputs compared against a packet-level
// timing model, plus reset, held-valid spacing and byte-reassembly checks.
module tb_packet_serializer;

  localparam int MAXC = 256;

  logic         rclk;
  logic         rrst_n;
  logic [255:0] packet_data;
  logic         packet_valid;
  logic         packet_ready;
  logic         fifo_full;
  logic         fifo_wr_en;
  logic [7:0]   fifo_wdata;
  logic         packet_done;
  logic         busy;
  logic [4:0]   byte_count;

  packet_serializer dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .packet_data  (packet_data),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wdata   (fifo_wdata),
    .packet_done  (packet_done),
    .busy         (busy),
    .byte_count   (byte_count)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int tests = 0;
  int fails = 0;

  // Stimulus pattern per cycle (cycle 0 is the first driven cycle of a run).
  logic         val_pat [MAXC];
  logic         full_pat[MAXC];
  logic [255:0] pkt_a;
  logic [255:0] pkt_b;
  int           sw_cyc;

  // Packed view per cycle: {wr_en, wdata[7:0], done, ready, busy, count[4:0]}
  logic [16:0]  obs  [MAXC];
  logic [16:0]  exp_v[MAXC];
  int           acc_cyc[$];

  function automatic logic [255:0] ramp(input logic [7:0] base);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[255-8*i -: 8] = base + 8'(i);
    return r;
  endfunction

  function automatic logic [255:0] rand_pkt();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_pats();
    for (int c = 0; c < MAXC; c++) begin
      val_pat[c]  = 1'b0;
      full_pat[c] = 1'b0;
    end
    sw_cyc = MAXC;
  endtask

  // Packet-level model: a packet is taken on any idle cycle with valid high, its
  // 32 bytes go out MSB-first on the following non-full cycles, the done pulse
  // follows the last write, and the block is idle again one cycle later.
  task automatic build_model(input int n);
    int t;
    int c;
    int sent;
    logic [255:0] pkt;
    for (int k = 0; k < MAXC; k++) exp_v[k] = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0};
    acc_cyc.delete();
    t = 0;
    while (t < n) begin
      if (!val_pat[t]) begin
        t++;
        continue;
      end
      pkt = (t < sw_cyc) ? pkt_a : pkt_b;
      acc_cyc.push_back(t);
      sent = 0;
      c = t + 1;
      while (sent < 32 && c < n) begin
        exp_v[c] = {!full_pat[c], pkt[255-8*sent -: 8], 1'b0, 1'b0, 1'b1, 5'(sent)};
        if (!full_pat[c]) sent++;
        c++;
      end
      if (c < n) exp_v[c] = {1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0};
      t = c + 1;
    end
  endtask

  task automatic run_cycles(input int n, input bit drain);
    for (int c = 0; c < n; c++) begin
      @(negedge rclk);
      packet_valid = val_pat[c];
      packet_data  = (c < sw_cyc) ? pkt_a : pkt_b;
      fifo_full    = full_pat[c];
      #1;
      obs[c] = {fifo_wr_en, fifo_wdata, packet_done, packet_ready, busy, byte_count};
    end
    if (drain) begin
      @(negedge rclk);
      packet_valid = 1'b0;
      fifo_full    = 1'b0;
      repeat (40) @(negedge rclk);
    end
  endtask

  task automatic test_reset();
    rrst_n       = 1'b0;
    packet_valid = 1'b1;
    packet_data  = rand_pkt();
    fifo_full    = 1'b0;
    repeat (2) @(negedge rclk);
    #1;
    tests++; if (packet_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", packet_ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (fifo_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
    tests++; if (fifo_wdata !== 8'h00) begin fails++; $display("FAIL reset_wdata got %h want 00", fifo_wdata); end
    tests++; if (packet_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", packet_done); end
    tests++; if (byte_count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", byte_count); end
    @(negedge rclk);
    packet_valid = 1'b0;
    rrst_n       = 1'b1;
    @(negedge rclk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    clear_pats();
    pkt_a = ramp(8'h00);
    val_pat[0] = 1'b1;
    build_model(35);
    run_cycles(35, 1'b1);
    for (int c = 0; c < 35; c++) begin
      tests++;
      if (obs[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL single cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", c, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_pats();
    pkt_a = ramp(8'h00);
    val_pat[0] = 1'b1;
    for (int c = 3; c <= 7; c++) full_pat[c] = 1'b1;
    full_pat[37] = 1'b1;  // cycle presenting byte 0x1F after five earlier stalls
    build_model(41);
    run_cycles(41, 1'b1);
    for (int c = 0; c < 41; c++) begin
      tests++;
      if (obs[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL backpressure cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", c, obs[c], exp_v[c]);
      end
    end
    tests++;
    if (obs[37][15:8] !== 8'h1F || obs[37][16] !== 1'b0) begin
      fails++;
      $display("FAIL backpressure_last_stall got wr=%b data=%h want wr=0 data=1f", obs[37][16], obs[37][15:8]);
    end
  endtask

  task automatic test_full_at_accept();
    clear_pats();
    pkt_a = ramp(8'h00);
    val_pat[0] = 1'b1;
    for (int c = 0; c < 5; c++) full_pat[c] = 1'b1;
    build_model(39);
    run_cycles(39, 1'b1);
    for (int c = 0; c < 39; c++) begin
      tests++;
      if (obs[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL full_at_accept cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", c, obs[c], exp_v[c]);
      end
    end
    tests++;
    if (obs[5][16] !== 1'b1 || obs[5][15:8] !== 8'h00) begin
      fails++;
      $display("FAIL full_at_accept_first_byte got wr=%b data=%h want wr=1 data=00", obs[5][16], obs[5][15:8]);
    end
  endtask

  task automatic test_held_valid();
    int obs_acc[$];
    clear_pats();
    pkt_a  = ramp(8'h00);
    pkt_b  = ramp(8'hA0);
    sw_cyc = 1;
    for (int c = 0; c < 68; c++) val_pat[c] = 1'b1;
    build_model(68);
    run_cycles(68, 1'b1);
    for (int c = 0; c < 68; c++) begin
      tests++;
      if (obs[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL held_valid cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", c, obs[c], exp_v[c]);
      end
      if (obs[c][6] && val_pat[c]) obs_acc.push_back(c);
    end
    tests++;
    if (obs_acc.size() != 2) begin
      fails++;
      $display("FAIL held_valid_accepts got %0d want 2", obs_acc.size());
    end else begin
      tests++;
      if (obs_acc[1] - obs_acc[0] != 34) begin
        fails++;
        $display("FAIL held_valid_spacing got %0d want 34", obs_acc[1] - obs_acc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_pats();
    pkt_a = rand_pkt();
    val_pat[0] = 1'b1;
    build_model(11);
    run_cycles(11, 1'b0);
    for (int c = 0; c < 11; c++) begin
      tests++;
      if (obs[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL reset_mid_pre cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", c, obs[c], exp_v[c]);
      end
    end
    @(negedge rclk);
    packet_valid = 1'b0;
    #1;
    tests++; if (byte_count !== 5'd10) begin fails++; $display("FAIL reset_mid_count got %0d want 10", byte_count); end
    rrst_n = 1'b0;
    #1;
    tests++;
    if ({fifo_wr_en, fifo_wdata, packet_done, packet_ready, busy, byte_count} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0}) begin
      fails++;
      $display("FAIL reset_mid_async got wr=%b data=%h done=%b rdy=%b busy=%b cnt=%0d want 0/00/0/1/0/0",
               fifo_wr_en, fifo_wdata, packet_done, packet_ready, busy, byte_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge rclk);
      #1;
      tests++; if (packet_done !== 1'b0) begin fails++; $display("FAIL reset_mid_no_done got %b want 0", packet_done); end
    end
    rrst_n = 1'b1;
    clear_pats();
    pkt_a = rand_pkt();
    val_pat[0] = 1'b1;
    build_model(35);
    run_cycles(35, 1'b1);
    for (int c = 0; c < 35; c++) begin
      tests++;
      if (obs[c] !== exp_v[c]) begin
        fails++;
        $display("FAIL reset_mid_next cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", c, obs[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_loopback_random();
    logic [255:0] rx;
    int nwr;
    for (int k = 0; k < 4; k++) begin
      clear_pats();
      pkt_a = rand_pkt();
      val_pat[0] = 1'b1;
      for (int c = 0; c < 80; c++) full_pat[c] = ($urandom_range(0, 2) == 0);
      build_model(120);
      run_cycles(120, 1'b1);
      rx  = '0;
      nwr = 0;
      for (int c = 0; c < 120; c++) begin
        tests++;
        if (obs[c] !== exp_v[c]) begin
          fails++;
          $display("FAIL random[%0d] cycle %0d: {wr,data,done,rdy,busy,cnt} got %h want %h", k, c, obs[c], exp_v[c]);
        end
        if (obs[c][16]) begin
          rx = {rx[247:0], obs[c][15:8]};
          nwr++;
        end
      end
      tests++;
      if (nwr != 32 || rx !== pkt_a) begin
        fails++;
        $display("FAIL loopback[%0d] got %0d bytes, %h want 32 bytes, %h", k, nwr, rx, pkt_a);
      end
    end
  endtask

  initial begin
    rrst_n       = 1'b0;
    packet_valid = 1'b0;
    packet_data  = '0;
    fifo_full    = 1'b0;
    pkt_a        = '0;
    pkt_b        = '0;
    sw_cyc       = MAXC;
    test_reset();
    test_single();
    test_backpressure();
    test_full_at_accept();
    test_held_valid();
    test_reset_mid();
    test_loopback_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
